// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants and state types for the UART command decoder and its response sender.
// Latency: none (types and constants only).
// Backpressure: n/a.
package uart_cmd_decoder_pkg;

    // Default frame marker and response bytes
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

    // Opcodes carried in the CMD byte
    localparam logic [7:0] CMD_SET_CODE = 8'h01;
    localparam logic [7:0] CMD_FIRE     = 8'h02;
    localparam logic [7:0] CMD_READ     = 8'h03;

    // Frame assembly states. RESP covers the whole ACK/NAK handshake,
    // which the response sender sequences in detail.
    typedef enum logic [2:0] {
        W_HDR,
        W_CMD,
        W_ARG,
        W_CHK,
        EXEC,
        RESP
    } dec_state_e;

    // Response sender states: RESP holds start_tx, W_IDLE waits for tx_busy to drop
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_RESP,
        TX_W_IDLE
    } tx_state_e;

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_tx_req.sv
// Sends one byte to uart_tx with the start_tx/tx_busy handshake.
// Latency: start_tx rises 1 clk after send_i; done_o pulses in the cycle tx_busy is seen low again.
// Backpressure: start_tx held until tx_busy is sampled 1; send_i is only honoured when idle.
module uart_cmd_decoder_tx_req
    import uart_cmd_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       send_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic       start_tx_o,
    output logic [7:0] data_o,
    output logic       done_o
);

    tx_state_e  state_q;
    logic       start_q;
    logic [7:0] data_q;

    // Handshake sequencer: raise start_tx, drop it once uart_tx goes busy, then wait for it to finish
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            start_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (send_i) begin
                        start_q <= 1'b1;
                        data_q  <= byte_i;
                        state_q <= TX_RESP;
                    end
                end
                TX_RESP: begin
                    if (tx_busy_i) begin
                        start_q <= 1'b0;
                        state_q <= TX_W_IDLE;
                    end
                end
                TX_W_IDLE: begin
                    if (!tx_busy_i) begin
                        state_q <= TX_IDLE;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign start_tx_o = start_q;
    assign data_o     = data_q;
    assign done_o     = (state_q == TX_W_IDLE) && !tx_busy_i;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles HDR/CMD/ARG/CHK frames from uart_rx, drives firing controls and answers ACK/NAK.
// Latency: fire_pulse/adc_req 1 clk after the CHK byte's rx_done; start_tx 1 clk after that.
// Backpressure: none toward uart_rx; bytes arriving while a response is in flight are dropped.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEF,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 480000,
    parameter int unsigned NUM_CODES      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       tx_busy,
    output logic       start_tx,
    output logic [7:0] data_to_tx,
    output logic [2:0] fire_code,
    output logic       code_valid,
    output logic       fire_pulse,
    output logic       adc_req,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    dec_state_e    state_q;
    logic [TW-1:0] cnt_q;
    logic [7:0]    cmd_q;
    logic [7:0]    arg_q;
    logic          ok_q;
    logic [2:0]    fire_code_q;
    logic          code_valid_q;
    logic          fire_pulse_q;
    logic          adc_req_q;
    logic [7:0]    err_q;

    logic       in_frame;
    logic       early_rej;
    logic       cmd_ok;
    logic       frame_ok;
    logic       send;
    logic [7:0] send_byte;
    logic       tx_done;

    // Frame checks; the verdict is taken on the CHK byte edge so the action is visible during EXEC
    always_comb begin
        in_frame  = (state_q == W_CMD) || (state_q == W_ARG) || (state_q == W_CHK);
        // a byte in the same cycle as the timeout wins; only its parity can reject it
        early_rej = in_frame && (rx_done ? parity_error : (cnt_q == TO_MAX));
        case (cmd_q)
            CMD_SET_CODE: cmd_ok = (32'(arg_q) < NUM_CODES);
            CMD_FIRE:     cmd_ok = code_valid_q;
            CMD_READ:     cmd_ok = 1'b1;
            default:      cmd_ok = 1'b0;
        endcase
        frame_ok  = ((cmd_q ^ arg_q) == rx_data) && cmd_ok;
        send      = early_rej || (state_q == EXEC);
        send_byte = ((state_q == EXEC) && ok_q) ? ACK_BYTE : NAK_BYTE;
    end

    // Frame FSM with registered firing outputs and saturating reject counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= W_HDR;
            cnt_q        <= '0;
            cmd_q        <= 8'h00;
            arg_q        <= 8'h00;
            ok_q         <= 1'b0;
            fire_code_q  <= 3'd0;
            code_valid_q <= 1'b0;
            fire_pulse_q <= 1'b0;
            adc_req_q    <= 1'b0;
            err_q        <= 8'h00;
        end else begin
            fire_pulse_q <= 1'b0;
            adc_req_q    <= 1'b0;
            if (early_rej || ((state_q == EXEC) && !ok_q)) begin
                err_q <= sat_inc8(err_q);
            end
            case (state_q)
                W_HDR: begin
                    cnt_q <= '0;
                    if (rx_done && !parity_error && (rx_data == HDR_BYTE)) begin
                        state_q <= W_CMD;
                    end
                end
                W_CMD, W_ARG, W_CHK: begin
                    if (early_rej) begin
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end else if (rx_done) begin
                        cnt_q <= '0;
                        if (state_q == W_CMD) begin
                            cmd_q   <= rx_data;
                            state_q <= W_ARG;
                        end else if (state_q == W_ARG) begin
                            arg_q   <= rx_data;
                            state_q <= W_CHK;
                        end else begin
                            ok_q    <= frame_ok;
                            state_q <= EXEC;
                            if (frame_ok) begin
                                case (cmd_q)
                                    CMD_SET_CODE: begin
                                        fire_code_q  <= arg_q[2:0];
                                        code_valid_q <= 1'b1;
                                    end
                                    CMD_FIRE: fire_pulse_q <= 1'b1;
                                    CMD_READ: adc_req_q    <= 1'b1;
                                    default: ;
                                endcase
                            end
                        end
                    end else begin
                        // cannot pass TO_MAX: reaching it rejects the frame above
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                EXEC: state_q <= RESP;
                RESP: begin
                    if (tx_done) begin
                        state_q <= W_HDR;
                    end
                end
                default: state_q <= W_HDR;
            endcase
        end
    end

    uart_cmd_decoder_tx_req u_tx_req (
        .clk        (clk),
        .reset      (reset),
        .send_i     (send),
        .byte_i     (send_byte),
        .tx_busy_i  (tx_busy),
        .start_tx_o (start_tx),
        .data_o     (data_to_tx),
        .done_o     (tx_done)
    );

    assign fire_code  = fire_code_q;
    assign code_valid = code_valid_q;
    assign fire_pulse = fire_pulse_q;
    assign adc_req    = adc_req_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: random and directed frames against a frame-level model.
// Latency: response and pulse cycles are checked against the byte strobe cycle.
// Backpressure: a uart_tx stand-in answers start_tx with a randomly delayed tx_busy pulse.
module tb_uart_cmd_decoder;

    localparam int TO = 200;
    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       parity_error = 1'b0;
    logic       tx_busy = 1'b0;
    logic       start_tx;
    logic [7:0] data_to_tx;
    logic [2:0] fire_code;
    logic       code_valid;
    logic       fire_pulse;
    logic       adc_req;
    logic [7:0] err_count;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .tx_busy      (tx_busy),
        .start_tx     (start_tx),
        .data_to_tx   (data_to_tx),
        .fire_code    (fire_code),
        .code_valid   (code_valid),
        .fire_pulse   (fire_pulse),
        .adc_req      (adc_req),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic [7:0] err;
        logic [2:0] code;
        logic       cv;
        int         cyc;
    } resp_t;

    typedef struct {
        int   cyc;
        logic fire;
        logic adc;
    } pulse_t;

    resp_t  exp_q[$];
    pulse_t pul_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int resp_seen = 0;
    int resp_target = 0;
    bit tx_active = 1'b0;

    // Reference model state: what the board should hold after each frame
    int m_code = 0;
    bit m_cv = 1'b0;
    int m_err = 0;

    logic   mon_prev = 1'b0;
    resp_t  mon_r;
    pulse_t mon_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_resp(input bit ok, input int c);
        resp_t r;
        if (!ok) m_err = (m_err < 255) ? m_err + 1 : 255;
        r.b    = ok ? ACK : NAK;
        r.err  = 8'(m_err);
        r.code = 3'(m_code);
        r.cv   = m_cv;
        r.cyc  = c;
        exp_q.push_back(r);
        resp_target++;
    endtask

    // Frame-level rules: checksum, opcode, argument range and FIRE precondition
    task automatic model_exec(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk, input int c);
        bit ok = 1'b0;
        pulse_t p;
        if ((cmd ^ arg) == chk) begin
            if (cmd == 8'd1) ok = (int'(arg) < 6);
            else if (cmd == 8'd2) ok = m_cv;
            else if (cmd == 8'd3) ok = 1'b1;
        end
        if (ok) begin
            p.cyc  = c + 1;
            p.fire = (cmd == 8'd2);
            p.adc  = (cmd == 8'd3);
            if (cmd == 8'd1) begin
                m_code = int'(arg);
                m_cv   = 1'b1;
            end else begin
                pul_q.push_back(p);
            end
        end
        push_resp(ok, c + 2);
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit perr, output int c);
        @(posedge clk);
        #1;
        rx_data      = b;
        rx_done      = 1'b1;
        parity_error = perr;
        c            = cyc;
        @(posedge clk);
        #1;
        rx_done      = 1'b0;
        parity_error = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while ((tx_active || tx_busy || start_tx) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("tx_idle", {29'd0, tx_active, tx_busy, start_tx}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (resp_seen < resp_target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("resp_arrived", resp_seen, resp_target);
        wait_tx_idle();
    endtask

    // perr_idx: byte carrying a parity error (-1 none); to_idx: go silent before this byte (-1 none)
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk,
                              input int perr_idx, input int to_idx, input bit stray, input int maxgap);
        logic [7:0] b [4];
        int c;
        int cs;
        b[0] = HDR;
        b[1] = cmd;
        b[2] = arg;
        b[3] = chk;
        for (int i = 0; i < 4; i++) begin
            if (i == to_idx) begin
                push_resp(1'b0, -1);
                repeat (2 * TO + 20) @(posedge clk);
                wait_resp();
                return;
            end
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            drive_byte(b[i], (i == perr_idx), c);
            if (i == perr_idx) begin
                if (i == 0) return;
                push_resp(1'b0, c + 1);
                wait_resp();
                return;
            end
        end
        model_exec(cmd, arg, chk, c);
        if (stray) drive_byte(HDR, 1'b0, cs);
        wait_resp();
    endtask

    // Clock cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // uart_tx stand-in: picks up start_tx after a short delay and stays busy for a while
    initial begin
        forever begin
            @(negedge clk);
            if (start_tx && !tx_busy) begin
                tx_active = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat ($urandom_range(3, 8)) @(posedge clk);
                #1 tx_busy = 1'b0;
                tx_active = 1'b0;
            end
        end
    end

    // Monitor: compares each response launch and each strobe with the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (start_tx && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got byte %0h, none pending (cycle %0d)", data_to_tx, cyc);
                end else begin
                    mon_r = exp_q.pop_front();
                    check("resp_byte", data_to_tx, mon_r.b);
                    check("resp_err_count", err_count, mon_r.err);
                    check("resp_fire_code", fire_code, mon_r.code);
                    check("resp_code_valid", code_valid, mon_r.cv);
                    if (mon_r.cyc >= 0) check("resp_cycle", cyc, mon_r.cyc);
                    resp_seen++;
                end
            end
            mon_prev = start_tx;
            if (fire_pulse || adc_req) begin
                if (pul_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got fire=%0b adc=%0b, none pending (cycle %0d)", fire_pulse, adc_req, cyc);
                end else begin
                    mon_p = pul_q.pop_front();
                    check("pulse_cycle", cyc, mon_p.cyc);
                    check("pulse_fire", fire_pulse, mon_p.fire);
                    check("pulse_adc", adc_req, mon_p.adc);
                end
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded 90000 cycles (resp %0d of %0d)", resp_seen, resp_target);
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_tx"}, start_tx, 0);
        check({tag, "_data_to_tx"}, data_to_tx, 0);
        check({tag, "_fire_code"}, fire_code, 0);
        check({tag, "_code_valid"}, code_valid, 0);
        check({tag, "_fire_pulse"}, fire_pulse, 0);
        check({tag, "_adc_req"}, adc_req, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    int         r;
    int         pe;
    int         to;
    int         c0;
    int         n;
    logic [7:0] cmd;
    logic [7:0] arg;
    logic [7:0] chk;
    logic [7:0] gb;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Directed frames
        send_frame(8'h02, 8'h00, 8'h02, -1, -1, 1'b0, 3);   // FIRE before any code: NAK
        send_frame(8'h01, 8'h03, 8'h02, -1, -1, 1'b0, 3);   // SET_CODE 3: ACK
        send_frame(8'h02, 8'h00, 8'h02, -1, -1, 1'b1, 0);   // FIRE: pulse + ACK, stray byte dropped
        send_frame(8'h01, 8'h06, 8'h07, -1, -1, 1'b0, 3);   // arg out of range: NAK
        send_frame(8'h01, 8'h02, 8'h00, -1, -1, 1'b0, 3);   // bad checksum: NAK
        check("fire_code_kept", fire_code, 3'(m_code));
        check("code_valid_kept", code_valid, m_cv);
        check("err_count_directed", err_count, 8'(m_err));
        send_frame(8'h03, 8'h00, 8'h03, -1, 2, 1'b0, 3);    // silence after CMD: timeout NAK
        send_frame(8'h03, 8'h00, 8'h03, -1, -1, 1'b0, 3);   // READ: adc_req + ACK
        drive_byte(8'h11, 1'b0, c0);
        drive_byte(8'h22, 1'b0, c0);
        repeat (30) @(posedge clk);
        #1;
        check("no_resp_to_garbage", start_tx, 0);
        send_frame(8'h01, 8'h04, 8'h05, 2, -1, 1'b0, 3);    // parity on ARG: NAK
        send_frame(8'h01, 8'h04, 8'h05, 0, -1, 1'b0, 3);    // parity on HDR: frame ignored
        send_frame(8'h01, 8'h04, 8'h05, -1, -1, 1'b0, 3);   // SET_CODE 4: ACK

        // Randomised frames
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                gb = 8'($urandom_range(0, 255));
                if (gb == HDR) gb = 8'h5A;
                drive_byte(gb, 1'($urandom_range(0, 1)), c0);
            end
            r = $urandom_range(0, 9);
            if (r < 3) cmd = 8'h01;
            else if (r < 5) cmd = 8'h02;
            else if (r < 7) cmd = 8'h03;
            else cmd = 8'($urandom_range(0, 255));
            arg = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            chk = cmd ^ arg;
            if ($urandom_range(0, 6) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            pe = -1;
            to = -1;
            r = $urandom_range(0, 29);
            if (r < 3) pe = $urandom_range(0, 3);
            else if (r == 3) to = $urandom_range(1, 3);
            send_frame(cmd, arg, chk, pe, to, ($urandom_range(0, 3) == 0), 12);
        end

        // Saturation of the reject counter
        for (int k = 0; k < 300; k++) begin
            send_frame(8'h01, 8'h00, 8'hFF, -1, -1, 1'b0, 0);
        end
        check("err_count_saturated", err_count, 8'd255);

        // Reset while start_tx is high
        drive_byte(HDR, 1'b0, c0);
        drive_byte(8'h03, 1'b0, c0);
        drive_byte(8'h00, 1'b0, c0);
        drive_byte(8'h03, 1'b0, c0);
        model_exec(8'h03, 8'h00, 8'h03, c0);
        n = 0;
        while (!start_tx && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("start_before_reset", start_tx, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midresp_reset");
        m_code = 0;
        m_cv   = 1'b0;
        m_err  = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_tx_idle();
        send_frame(8'h01, 8'h05, 8'h04, -1, -1, 1'b0, 3);   // SET_CODE 5: ACK
        send_frame(8'h02, 8'h00, 8'h02, -1, -1, 1'b0, 3);   // FIRE: ACK

        repeat (10) @(posedge clk);
        check("resp_queue_drained", exp_q.size(), 0);
        check("pulse_queue_drained", pul_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
